// File: rtl/spi_master_tx_pkg.sv
// Shared types and defaults for the mode-0 SPI master transmitter.
package spi_master_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam int DEFAULT_CLK_DIV = 4;
  localparam int DEFAULT_DATA_W  = 8;
  localparam int DEFAULT_CS_GAP  = 1;

  // Counter width that stays legal when the count range collapses to a single value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_tx_clk_div.sv
// Half-period divider for the SPI master: counts 0..DIV-1 and flags the last cycle.
module spi_clk_div
  import spi_master_tx_pkg::*;
#(
  parameter int DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over enable, wrap on the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_tx.sv
// Single-transfer SPI master, mode 0, MSB first, full duplex with registered pin outputs.
module spi_master_tx
  import spi_master_tx_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CS_GAP  = DEFAULT_CS_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int            BW       = cnt_width(DATA_W);
  localparam int            GW       = cnt_width(CS_GAP);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  state_e            state_q,   state_d;
  logic [DATA_W-1:0] tx_sr_q,   tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q,   rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick_s;
  logic              load_s;

  spi_clk_div #(.DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q != ST_IDLE),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick_s)
  );

  // A start is taken in IDLE, or on the closing tick of the gap so held starts run back to back.
  always_comb begin
    load_s = 1'b0;
    if (state_q == ST_IDLE) begin
      load_s = start;
    end else if ((state_q == ST_GAP) && tick_s && (gap_cnt_q == GAP_LAST)) begin
      load_s = start;
    end else begin
      load_s = 1'b0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_SETUP: begin
        if (tick_s) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
        end else begin
          sclk_d  = 1'b0;
        end
      end
      ST_HIGH: begin
        if (tick_s) begin
          state_d = ST_LOW;
          sclk_d  = 1'b0;
          if (bit_cnt_q != LAST_BIT) begin
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            mosi_d  = tx_sr_q[DATA_W-2];
          end else begin
            mosi_d  = mosi_q;
          end
        end else begin
          sclk_d  = 1'b1;
        end
      end
      ST_LOW: begin
        if (tick_s) begin
          if (bit_cnt_q != LAST_BIT) begin
            state_d   = ST_HIGH;
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            rx_sr_d   = {rx_sr_q[DATA_W-2:0], miso};
          end else begin
            state_d   = ST_GAP;
            rx_data_d = rx_sr_q;
            cs_n_d    = 1'b1;
            mosi_d    = 1'b0;
            done_d    = 1'b1;
            gap_cnt_d = '0;
          end
        end else begin
          sclk_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end else begin
          cs_n_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sclk_d  = CPOL;
        mosi_d  = 1'b0;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (load_s) begin
      state_d   = ST_SETUP;
      tx_sr_d   = tx_data;
      rx_sr_d   = '0;
      bit_cnt_d = '0;
      mosi_d    = tx_data[DATA_W-1];
      cs_n_d    = 1'b0;
      busy_d    = 1'b1;
      sclk_d    = CPOL;
    end else begin
      state_d   = state_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= CPOL;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: loopback, slave model, ignored starts, reset, fast divider.
module tb_spi_master_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       busy, done, sclk, mosi, miso, cs_n;
  logic [7:0] rx_data;

  logic       start_f;
  logic [7:0] tx_f;
  logic       busy_f, done_f, sclk_f, mosi_f, cs_n_f;
  logic [7:0] rx_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_master_tx u_dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
    .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_master_tx #(.CLK_DIV(1), .DATA_W(8), .CS_GAP(1)) u_fast (
    .clk(clk), .rst(rst), .start(start_f), .tx_data(tx_f), .busy(busy_f), .done(done_f),
    .rx_data(rx_f), .sclk(sclk_f), .mosi(mosi_f), .miso(mosi_f), .cs_n(cs_n_f)
  );

  // Simple SPI slave: shifts mosi in on sclk rise, presents a pattern on miso.
  logic       use_slv = 1'b0;
  logic [7:0] slv_pat = 8'h00;
  logic [7:0] slv_tx  = 8'h00;
  logic [7:0] slv_rx  = 8'h00;
  always @(negedge cs_n) slv_tx = slv_pat;
  always @(negedge sclk) if (!cs_n) slv_tx = {slv_tx[6:0], 1'b0};
  always @(posedge sclk) if (!cs_n) slv_rx = {slv_rx[6:0], mosi};
  assign miso = use_slv ? slv_tx[7] : mosi;

  int         cs_cnt, cs_first, cs_last, rises, done_cnt, done_cyc, busy_low;
  logic [7:0] seq, rx_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one transfer at the next edge (edge 0) and watch cycles 1..ncyc.
  task automatic run(input logic [7:0] d, input int ncyc, input bit repulse, input int rst_at);
    logic prev_sclk;
    cs_cnt = 0; cs_first = -1; cs_last = -1; rises = 0; done_cnt = 0; done_cyc = -1;
    busy_low = -1; seq = 8'h00; rx_at_done = 8'hxx; prev_sclk = 1'b0;
    @(negedge clk);
    start = 1'b1; tx_data = d;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (!cs_n) begin
        cs_cnt++;
        if (cs_first < 0) cs_first = c;
        cs_last = c;
      end
      if (sclk && !prev_sclk) begin
        rises++;
        seq = {seq[6:0], mosi};
      end
      prev_sclk = sclk;
      if (done) begin
        done_cnt++;
        done_cyc = c;
        rx_at_done = rx_data;
      end
      if (!busy && busy_low < 0) busy_low = c;
      start = repulse && (c == 10 || c == 40);
      if (c == 2) tx_data = ~d;
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx", rx_data, 8'h00);
        check("rst_mosi", mosi, 1'b0);
        prev_sclk = 1'b0;
      end
      if (c == rst_at + 2) rst = 1'b0;
    end
  endtask

  int         len_run, nlow, gaplen, nrx, last_rise, rises_f, bad_per;
  int         lowlen[2];
  logic [7:0] rxs[2];
  logic       prev_sf;

  initial begin
    rst = 1'b1; start = 1'b0; tx_data = 8'h00; start_f = 1'b0; tx_f = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_cs_n", cs_n, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rx", rx_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // 1: loopback A5
    run(8'hA5, 80, 1'b0, -1);
    check("t1_cs_cnt", cs_cnt, 68);
    check("t1_cs_first", cs_first, 1);
    check("t1_cs_last", cs_last, 68);
    check("t1_rises", rises, 8);
    check("t1_mosi_seq", seq, 8'hA5);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_cyc", done_cyc, 69);
    check("t1_rx_done", rx_at_done, 8'hA5);
    check("t1_busy_low", busy_low, 73);
    check("t1_rx_held", rx_data, 8'hA5);

    // 2: slave receives 3C then C3
    run(8'h3C, 80, 1'b0, -1);
    check("t2_slave_3c", slv_rx, 8'h3C);
    check("t2_rx_3c", rx_at_done, 8'h3C);
    run(8'hC3, 80, 1'b0, -1);
    check("t2_slave_c3", slv_rx, 8'hC3);
    check("t2_rx_c3", rx_at_done, 8'hC3);

    // 3: slave returns 5E while sending FF
    use_slv = 1'b1; slv_pat = 8'h5E;
    run(8'hFF, 80, 1'b0, -1);
    check("t3_rx", rx_at_done, 8'h5E);
    check("t3_mosi_seq", seq, 8'hFF);
    check("t3_slave_rx", slv_rx, 8'hFF);
    use_slv = 1'b0;

    // 4: extra starts during a transfer are ignored
    run(8'h81, 80, 1'b1, -1);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_rises", rises, 8);
    check("t4_rx", rx_at_done, 8'h81);
    check("t4_done_cyc", done_cyc, 69);

    // 5: reset mid-transfer, then a clean transfer
    run(8'hA5, 80, 1'b0, 30);
    check("t5_no_done", done_cnt, 0);
    check("t5_rx_zero", rx_data, 8'h00);
    run(8'h12, 80, 1'b0, -1);
    check("t5_fresh_rx", rx_at_done, 8'h12);
    check("t5_fresh_done", done_cyc, 69);

    // 6: CLK_DIV=1, start held high
    len_run = 0; nlow = 0; gaplen = 0; nrx = 0; last_rise = -1; rises_f = 0; bad_per = 0;
    lowlen[0] = -1; lowlen[1] = -1; rxs[0] = 8'hxx; rxs[1] = 8'hxx; prev_sf = 1'b0;
    @(negedge clk);
    start_f = 1'b1; tx_f = 8'h0F;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 1) tx_f = 8'hF0;
      if (c == 20) start_f = 1'b0;
      if (!cs_n_f) begin
        len_run++;
      end else begin
        if (len_run > 0 && nlow < 2) begin
          lowlen[nlow] = len_run;
          nlow++;
        end
        len_run = 0;
        if (nlow == 1) gaplen++;
      end
      if (sclk_f && !prev_sf && nlow == 0) begin
        rises_f++;
        if (last_rise >= 0 && (c - last_rise) != 2) bad_per++;
        last_rise = c;
      end
      prev_sf = sclk_f;
      if (done_f && nrx < 2) begin
        rxs[nrx] = rx_f;
        nrx++;
      end
    end
    check("t6_low0", lowlen[0], 17);
    check("t6_low1", lowlen[1], 17);
    check("t6_gap", gaplen, 1);
    check("t6_rises", rises_f, 8);
    check("t6_period", bad_per, 0);
    check("t6_rx0", rxs[0], 8'h0F);
    check("t6_rx1", rxs[1], 8'hF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
